// File: rtl/lc3_mon_pkg.sv
// Purpose: shared opcodes, core state codes, error codes and monitor FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lc3_mon_pkg;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_JSR = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOT = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1100;

   localparam logic [4:0] CORE_IDLE   = 5'b00000;
   localparam logic [4:0] CORE_FET0   = 5'b00001;
   localparam logic [4:0] CORE_DECODE = 5'b00100;

   typedef enum logic [3:0] {
      ERR_NONE       = 4'd0,
      ERR_ILLEGAL_OP = 4'd1,
      ERR_NO_WR      = 4'd2,
      ERR_EXTRA_WR   = 4'd3,
      ERR_BAD_DR     = 4'd4,
      ERR_BAD_DATA   = 4'd5,
      ERR_BAD_ADDR   = 4'd6,
      ERR_BAD_PC     = 4'd7,
      ERR_TIMEOUT    = 4'd8
   } err_code_e;

   typedef enum logic [1:0] {
      MON_IDLE     = 2'd0,
      MON_WAIT_DEC = 2'd1,
      MON_CHECK    = 2'd2,
      MON_DONE     = 2'd3
   } mon_state_e;

endpackage

// File: rtl/lc3_mon_golden.sv
// Purpose: reference model producing expected write data, store address and next PC.
// Latency: purely combinational.
// Backpressure: none; inputs are the instruction context captured at decode.
module lc3_mon_golden
   import lc3_mon_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] ir_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] sr1_i,
   input  logic [DATA_W-1:0] sr2_i,
   input  logic [DATA_W-1:0] drv_i,
   input  logic              n_i,
   input  logic              z_i,
   input  logic              p_i,
   output logic [DATA_W-1:0] data_o,
   output logic [DATA_W-1:0] addr_o,
   output logic [DATA_W-1:0] pc_o
);

   logic [DATA_W-1:0] off5, off9, off11, op2;
   logic              taken;

   assign off5  = {{(DATA_W-5){ir_i[4]}}, ir_i[4:0]};
   assign off9  = {{(DATA_W-9){ir_i[8]}}, ir_i[8:0]};
   assign off11 = {{(DATA_W-11){ir_i[10]}}, ir_i[10:0]};
   assign op2   = ir_i[5] ? off5 : sr2_i;
   assign taken = (n_i & ir_i[11]) | (z_i & ir_i[10]) | (p_i & ir_i[9]);
   assign addr_o = pc_i + off9;

   // Expected data and next PC by opcode; pc is the already-incremented PC
   always_comb begin
      data_o = '0;
      pc_o   = pc_i;
      case (ir_i[15:12])
         OP_ADD: data_o = sr1_i + op2;
         OP_AND: data_o = sr1_i & op2;
         OP_NOT: data_o = ~sr1_i;
         OP_ST:  data_o = drv_i;
         OP_BR:  pc_o   = taken ? pc_i + off9 : pc_i;
         OP_JMP: pc_o   = sr1_i;
         OP_JSR: begin
            data_o = pc_i;
            pc_o   = pc_i + off11;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lc3_retire_monitor.sv
// Purpose: shadows an LC-3 core and checks each retired instruction's writes and PC.
// Latency: errors/counts appear one cycle after the retiring FET0 (or the timeout cycle).
// Backpressure: none; passive observer. LC3_MON_HALT_EN adds a sticky halt_req output.
module lc3_retire_monitor
   import lc3_mon_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NUM_INST = 60,
   parameter int TIMEOUT  = 8,
   parameter int ERR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        state,
   input  logic [DATA_W-1:0] ir,
   input  logic [DATA_W-1:0] pc,
   input  logic              n,
   input  logic              z,
   input  logic              p,
   input  logic              reg_we,
   input  logic [2:0]        reg_dr,
   input  logic [DATA_W-1:0] reg_wdata,
   input  logic              mem_we,
   input  logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [15:0]       inst_count,
   output logic [ERR_W-1:0]  err_count,
   output logic              err_pulse,
   output logic [3:0]        err_code,
   output logic              done
`ifdef LC3_MON_HALT_EN
   ,
   output logic              halt_req
`endif
);

   localparam int               TMO_W   = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
   localparam logic [15:0]      NUM_LIM = 16'(NUM_INST);

   mon_state_e        st_q, st_d;
   logic [DATA_W-1:0] shadow_q [8];
   logic [DATA_W-1:0] ir_q, pc_q, sr1_q, sr2_q, drv_q;
   logic              n_q, z_q, p_q;
   logic              rw_vld_q, mw_vld_q, xw_q;
   logic [2:0]        rw_dr_q;
   logic [DATA_W-1:0] rw_dat_q, mw_addr_q, mw_dat_q;
   logic [TMO_W-1:0]  tmo_cnt_q;
   logic [15:0]       inst_cnt_q, inst_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              err_pulse_q;
   err_code_e         err_code_q, err_code_d, prio_code;
   logic              enter_chk, retire, tmo, err_fire;
   logic [DATA_W-1:0] exp_data, exp_addr, exp_pc;
   logic              need_rw, need_mw, chk_data, chk_pc, illegal;
   logic [2:0]        exp_dr;
   logic [7:0]        fail;

   lc3_mon_golden #(.DATA_W(DATA_W)) u_golden (
      .ir_i   (ir_q),
      .pc_i   (pc_q),
      .sr1_i  (sr1_q),
      .sr2_i  (sr2_q),
      .drv_i  (drv_q),
      .n_i    (n_q),
      .z_i    (z_q),
      .p_i    (p_q),
      .data_o (exp_data),
      .addr_o (exp_addr),
      .pc_o   (exp_pc)
   );

   // Monitor FSM next state; retire has priority over timeout in the same cycle
   always_comb begin
      st_d      = st_q;
      enter_chk = 1'b0;
      retire    = 1'b0;
      tmo       = 1'b0;
      case (st_q)
         MON_IDLE:     if (state == CORE_FET0) st_d = MON_WAIT_DEC;
         MON_WAIT_DEC: if (state == CORE_DECODE) begin
            st_d      = MON_CHECK;
            enter_chk = 1'b1;
         end
         MON_CHECK: begin
            if (state == CORE_FET0) begin
               retire = 1'b1;
               st_d   = (inst_cnt_d == NUM_LIM) ? MON_DONE : MON_WAIT_DEC;
            end else if (tmo_cnt_q == TMO_LIM) begin
               tmo  = 1'b1;
               st_d = MON_WAIT_DEC;
            end
         end
         default: st_d = MON_DONE;
      endcase
   end

   // Per-opcode expectations and the lowest-numbered failing error code
   always_comb begin
      need_rw  = 1'b0;
      need_mw  = 1'b0;
      chk_data = 1'b0;
      chk_pc   = 1'b0;
      illegal  = 1'b0;
      exp_dr   = ir_q[11:9];
      case (ir_q[15:12])
         OP_ADD, OP_AND, OP_NOT: begin
            need_rw  = 1'b1;
            chk_data = 1'b1;
         end
         OP_LD:          need_rw = 1'b1;
         OP_ST:          need_mw = 1'b1;
         OP_BR, OP_JMP:  chk_pc  = 1'b1;
         OP_JSR: begin
            need_rw  = 1'b1;
            chk_data = 1'b1;
            chk_pc   = 1'b1;
            exp_dr   = 3'd7;
         end
         default:        illegal = 1'b1;
      endcase
      fail               = '0;
      fail[ERR_ILLEGAL_OP] = illegal;
      fail[ERR_NO_WR]    = (need_rw && !rw_vld_q) || (need_mw && !mw_vld_q);
      fail[ERR_EXTRA_WR] = xw_q;
      fail[ERR_BAD_DR]   = need_rw && rw_vld_q && (rw_dr_q != exp_dr);
      fail[ERR_BAD_DATA] = (chk_data && rw_vld_q && (rw_dat_q != exp_data)) ||
                           (need_mw && mw_vld_q && (mw_dat_q != exp_data));
      fail[ERR_BAD_ADDR] = need_mw && mw_vld_q && (mw_addr_q != exp_addr);
      fail[ERR_BAD_PC]   = chk_pc && (pc != exp_pc);
      prio_code = ERR_NONE;
      for (int i = 7; i >= 1; i--) begin
         if (fail[i]) prio_code = err_code_e'(4'(i));
      end
      err_fire   = (retire && (fail != '0)) || tmo;
      err_code_d = tmo ? ERR_TIMEOUT : prio_code;
      inst_cnt_d = inst_cnt_q + 16'(retire);
      err_cnt_d  = (err_fire && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= MON_IDLE;
      else     st_q <= st_d;
   end

   // Shadow register file follows every core register write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
      end else if (reg_we) begin
         shadow_q[reg_dr] <= reg_wdata;
      end
   end

   // Capture context at decode; log first reg/mem write and flag repeats during CHECK
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_q      <= '0;
         pc_q      <= '0;
         sr1_q     <= '0;
         sr2_q     <= '0;
         drv_q     <= '0;
         n_q       <= 1'b0;
         z_q       <= 1'b0;
         p_q       <= 1'b0;
         rw_vld_q  <= 1'b0;
         mw_vld_q  <= 1'b0;
         xw_q      <= 1'b0;
         rw_dr_q   <= '0;
         rw_dat_q  <= '0;
         mw_addr_q <= '0;
         mw_dat_q  <= '0;
         tmo_cnt_q <= '0;
      end else if (enter_chk) begin
         ir_q      <= ir;
         pc_q      <= pc;
         sr1_q     <= shadow_q[ir[8:6]];
         sr2_q     <= shadow_q[ir[2:0]];
         drv_q     <= shadow_q[ir[11:9]];
         n_q       <= n;
         z_q       <= z;
         p_q       <= p;
         rw_vld_q  <= 1'b0;
         mw_vld_q  <= 1'b0;
         xw_q      <= 1'b0;
         tmo_cnt_q <= '0;
      end else if (st_q == MON_CHECK && !retire && !tmo) begin
         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         if (reg_we) begin
            if (rw_vld_q) xw_q <= 1'b1;
            else begin
               rw_vld_q <= 1'b1;
               rw_dr_q  <= reg_dr;
               rw_dat_q <= reg_wdata;
            end
         end
         if (mem_we) begin
            if (mw_vld_q) xw_q <= 1'b1;
            else begin
               mw_vld_q  <= 1'b1;
               mw_addr_q <= mem_addr;
               mw_dat_q  <= mem_wdata;
            end
         end
      end
   end

   // Retire count, saturating error count, one-cycle error strobe, last error code
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_cnt_q  <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         inst_cnt_q  <= inst_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_fire;
         if (err_fire) err_code_q <= err_code_d;
      end
   end

   assign inst_count = inst_cnt_q;
   assign err_count  = err_cnt_q;
   assign err_pulse  = err_pulse_q;
   assign err_code   = err_code_q;
   assign done       = (st_q == MON_DONE);

`ifdef LC3_MON_HALT_EN
   logic halt_q;

   // Halt request latches on the first detected error until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           halt_q <= 1'b0;
      else if (err_fire) halt_q <= 1'b1;
   end

   assign halt_req = halt_q;
`else
   // Without the halt option the monitor only reports; it never stops the core.
`endif

endmodule

// File: tb/tb_lc3_retire_monitor.sv
module tb_lc3_retire_monitor;
   import lc3_mon_pkg::*;

   localparam int DATA_W   = 16;
   localparam int NUM_INST = 4;
   localparam int TIMEOUT  = 8;
   localparam int ERR_W    = 8;
   localparam logic [4:0] CORE_EXEC = 5'b00010;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [4:0]        state = CORE_IDLE;
   logic [DATA_W-1:0] ir = '0, pc = '0;
   logic              n = 1'b0, z = 1'b0, p = 1'b0;
   logic              reg_we = 1'b0;
   logic [2:0]        reg_dr = '0;
   logic [DATA_W-1:0] reg_wdata = '0;
   logic              mem_we = 1'b0;
   logic [DATA_W-1:0] mem_addr = '0, mem_wdata = '0;
   logic [15:0]       inst_count;
   logic [ERR_W-1:0]  err_count;
   logic              err_pulse;
   logic [3:0]        err_code;
   logic              done;
`ifdef LC3_MON_HALT_EN
   logic              halt_req;
`endif

   int vec_cnt  = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   lc3_retire_monitor #(
      .DATA_W(DATA_W), .NUM_INST(NUM_INST), .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .rst(rst), .state(state), .ir(ir), .pc(pc),
      .n(n), .z(z), .p(p),
      .reg_we(reg_we), .reg_dr(reg_dr), .reg_wdata(reg_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .inst_count(inst_count), .err_count(err_count), .err_pulse(err_pulse),
      .err_code(err_code), .done(done)
`ifdef LC3_MON_HALT_EN
      , .halt_req(halt_req)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst    = 1'b1;
      state  = CORE_IDLE;
      reg_we = 1'b0;
      mem_we = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic wr_reg(input logic [2:0] dr, input logic [15:0] d);
      reg_we = 1'b1; reg_dr = dr; reg_wdata = d;
      tick();
      reg_we = 1'b0;
   endtask

   task automatic wr_mem(input logic [15:0] a, input logic [15:0] d);
      mem_we = 1'b1; mem_addr = a; mem_wdata = d;
      tick();
      mem_we = 1'b0;
   endtask

   task automatic fetch_decode(input logic [15:0] i, input logic [15:0] pcv, input logic [2:0] nzp);
      state = CORE_FET0;
      tick();
      state = CORE_DECODE; ir = i; pc = pcv; {n, z, p} = nzp;
      tick();
      state = CORE_EXEC;
   endtask

   task automatic retire_at(input logic [15:0] pcv);
      state = CORE_FET0; pc = pcv;
      tick();
      state = CORE_EXEC;
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_inst", inst_count, 0);
      chk("rst_errc", err_count, 0);
      chk("rst_pulse", err_pulse, 0);
      chk("rst_code", err_code, ERR_NONE);
      chk("rst_done", done, 0);
`ifdef LC3_MON_HALT_EN
      chk("rst_halt", halt_req, 0);
`endif

      // ADD R0,R1,R2 with R1=5, R2=3 -> R0=8 clean
      wr_reg(3'd1, 16'd5);
      wr_reg(3'd2, 16'd3);
      fetch_decode(16'h1042, 16'h3001, 3'b000);
      wr_reg(3'd0, 16'h0008);
      retire_at(16'h3001);
      chk("add_pulse", err_pulse, 0);
      chk("add_inst", inst_count, 1);

      // ADD R0,R1,#-1 expects 4, core writes 5
      fetch_decode(16'h107F, 16'h3002, 3'b000);
      wr_reg(3'd0, 16'h0005);
      retire_at(16'h3002);
      chk("addi_pulse", err_pulse, 1);
      chk("addi_code", err_code, ERR_BAD_DATA);
      chk("addi_errc", err_count, 1);
      tick();
      chk("pulse_1cyc", err_pulse, 0);
`ifdef LC3_MON_HALT_EN
      chk("halt_set", halt_req, 1);
`endif

      // BRz +4 taken, core stays at 0x0010
      fetch_decode(16'h0404, 16'h0010, 3'b010);
      retire_at(16'h0010);
      chk("br_bad_code", err_code, ERR_BAD_PC);
      chk("br_bad_errc", err_count, 2);
      chk("br_bad_inst", inst_count, 3);

      // Timeout: TIMEOUT cycles in CHECK are tolerated, the next one flags
      fetch_decode(16'h0404, 16'h0010, 3'b010);
      repeat (TIMEOUT) tick();
      chk("tmo_early", err_pulse, 0);
      tick();
      chk("tmo_pulse", err_pulse, 1);
      chk("tmo_code", err_code, ERR_TIMEOUT);
      chk("tmo_inst", inst_count, 3);

      // BRz +4 retiring at 0x0014 is clean and reaches NUM_INST
      fetch_decode(16'h0404, 16'h0010, 3'b010);
      retire_at(16'h0014);
      chk("br_ok_pulse", err_pulse, 0);
      chk("br_ok_inst", inst_count, 4);
      chk("br_ok_done", done, 1);
      fetch_decode(16'h0404, 16'h0010, 3'b010);
      retire_at(16'h0010);
      chk("done_hold_inst", inst_count, 4);
      chk("done_hold_errc", err_count, 3);
`ifdef LC3_MON_HALT_EN
      chk("halt_hold", halt_req, 1);
`endif

      // ST R3 (0xBEEF) at pc 0x0020 offset 2
      do_reset();
      chk("rst2_done", done, 0);
      wr_reg(3'd3, 16'hBEEF);
      fetch_decode(16'h3602, 16'h0020, 3'b000);
      wr_mem(16'h0022, 16'hBEEF);
      retire_at(16'h0021);
      chk("st_ok_pulse", err_pulse, 0);
      chk("st_ok_inst", inst_count, 1);
      fetch_decode(16'h3602, 16'h0020, 3'b000);
      tick();
      retire_at(16'h0021);
      chk("st_nowr_code", err_code, ERR_NO_WR);
      fetch_decode(16'hF025, 16'h0022, 3'b000);
      retire_at(16'h0022);
      chk("illegal_code", err_code, ERR_ILLEGAL_OP);
      chk("illegal_inst", inst_count, 3);
      chk("illegal_errc", err_count, 2);

      // Reset in the middle of CHECK clears everything immediately
      fetch_decode(16'h1042, 16'h0023, 3'b000);
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_inst", inst_count, 0);
      chk("midrst_errc", err_count, 0);
      chk("midrst_code", err_code, 0);
      chk("midrst_pulse", err_pulse, 0);
`ifdef LC3_MON_HALT_EN
      chk("midrst_halt", halt_req, 0);
`endif
      tick();
      rst = 1'b0;
      tick();
      chk("postrst_pulse", err_pulse, 0);

      // Four clean retires: JSR, JMP R7, AND R1,R7,#15, NOT R2,R7
      fetch_decode(16'h4803, 16'h0040, 3'b000);
      wr_reg(3'd7, 16'h0040);
      retire_at(16'h0043);
      chk("jsr_pulse", err_pulse, 0);
      fetch_decode(16'hC1C0, 16'h0044, 3'b000);
      retire_at(16'h0040);
      chk("jmp_pulse", err_pulse, 0);
      fetch_decode(16'h53EF, 16'h0041, 3'b000);
      wr_reg(3'd1, 16'h0000);
      retire_at(16'h0042);
      chk("and_pulse", err_pulse, 0);
      fetch_decode(16'h95FF, 16'h0042, 3'b000);
      wr_reg(3'd2, 16'hFFBF);
      retire_at(16'h0043);
      chk("not_pulse", err_pulse, 0);
      chk("four_inst", inst_count, 4);
      chk("four_done", done, 1);
      chk("four_errc", err_count, 0);
      fetch_decode(16'h95FF, 16'h0043, 3'b000);
      wr_reg(3'd2, 16'hFFBF);
      retire_at(16'h0044);
      chk("fifth_inst", inst_count, 4);

      // Wrong DR and wrong data together report BAD_DR; double write is EXTRA_WR
      do_reset();
      fetch_decode(16'h1042, 16'h0050, 3'b000);
      wr_reg(3'd5, 16'h0009);
      retire_at(16'h0051);
      chk("multi_code", err_code, ERR_BAD_DR);
      chk("multi_errc", err_count, 1);
      fetch_decode(16'h2800, 16'h0051, 3'b000);
      wr_reg(3'd4, 16'h1111);
      wr_reg(3'd4, 16'h2222);
      retire_at(16'h0052);
      chk("extra_code", err_code, ERR_EXTRA_WR);
      chk("extra_errc", err_count, 2);

      // Error counter saturates at all-ones
      for (int k = 0; k < 260; k++) begin
         fetch_decode(16'h0000, 16'h0060, 3'b000);
         repeat (TIMEOUT + 1) tick();
      end
      chk("sat_errc", err_count, 8'hFF);
      chk("sat_code", err_code, ERR_TIMEOUT);
      chk("sat_inst", inst_count, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
